alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Front end for the N-bit arithmetic element array and the adder behind it.
// Takes one opcode word and two operand words over a valid/ready input bus.
// Holds the mode, select and operand lines stable while the adder settles.
// Captures the sum and its flags, then returns them over a valid/ready
// output bus.
//
// Optional feature: define ALU_SEQ_CHAIN_EN to enable operation chaining.
// When it is enabled, opcode bit 3 reuses the last captured result as A and
// skips the A word.
module alu_op_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         m,
    output logic [1:0]   s,
    output logic [N-1:0] b_op,
    output logic [N-1:0] a_op,
    input  logic [N-1:0] sum,
    input  logic         cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        EXEC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t       state_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         m_q;
    logic [1:0]   s_q;
    logic [N-1:0] a_op_q;
    logic [N-1:0] b_op_q;
    logic [N-1:0] result_q;
    logic         carry_q;
    logic         zero_q;

    logic         in_xfer_d;
    logic         out_xfer_d;

    // Only bits 3:0 of the opcode word carry meaning.
    // Bit 3 is meaningful only when chaining is built in.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^in_data[N-1:3];

    // Handshake qualifiers.
    assign in_xfer_d  = in_valid && in_ready_q;
    assign out_xfer_d = out_valid_q && out_ready;

    // Sequencer FSM.
    // Every output is a register, so the array control lines never glitch.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments, so every register
        // in this block samples values from before the edge.
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_q         <= 1'b0;
            s_q         <= 2'b00;
            a_op_q      <= '0;
            b_op_q      <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_xfer_d) begin
                        m_q <= in_data[2];
                        s_q <= in_data[1:0];
`ifdef ALU_SEQ_CHAIN_EN
                        if (in_data[3]) begin
                            // Chain: the previous result becomes the A operand.
                            a_op_q  <= result_q;
                            state_q <= GET_B;
                        end else begin
                            state_q <= GET_A;
                        end
`else
                        state_q <= GET_A;
`endif
                    end
                end

                GET_A: begin
                    if (in_xfer_d) begin
                        a_op_q  <= in_data;
                        state_q <= GET_B;
                    end
                end

                GET_B: begin
                    if (in_xfer_d) begin
                        b_op_q     <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= EXEC;
                    end
                end

                EXEC: begin
                    // The operands have been stable for a full clock.
                    // Capture the adder outputs now.
                    result_q    <= sum;
                    carry_q     <= cout;
                    zero_q      <= (sum == '0);
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end

                DONE: begin
                    if (out_xfer_d) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign m         = m_q;
    assign s         = s_q;
    assign a_op      = a_op_q;
    assign b_op      = b_op_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer (N = 8).
// The arithmetic element array is modelled as passing B through unchanged.
// The adder model is therefore {cout, sum} = a_op + b_op.
module tb_alu_op_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         m;
    logic [1:0]   s;
    logic [N-1:0] b_op;
    logic [N-1:0] a_op;
    logic [N-1:0] sum;
    logic         cout;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         carry;
    logic         zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {cout, sum} = {1'b0, a_op} + {1'b0, b_op};

    alu_op_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .m         (m),
        .s         (s),
        .b_op      (b_op),
        .a_op      (a_op),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    // Advance one rising edge, then settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run a full unchained operation from IDLE with in_valid held high.
    // The task returns just after the EXEC capture edge.
    task automatic do_op(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = opc;
        tick();
        in_data  = a;
        tick();
        in_data  = b;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_op(8'h00, 8'h2A, 8'h30);
        checks++;
        if ({out_valid, result} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL reset_setup: out_valid/result got %b/%h want 1/5a", out_valid, result);
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, m, s, a_op, b_op, result, carry, zero} !==
            {1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b ov=%b m=%b s=%b a=%h b=%h res=%h c=%b z=%b",
                     in_ready, out_valid, m, s, a_op, b_op, result, carry, zero);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h06;
        tick();
        checks++;
        if ({m, s, in_ready} !== {1'b1, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL basic_opcode: m=%b s=%b rdy=%b want m=1 s=10 rdy=1", m, s, in_ready);
        end
        in_data = 8'h12;
        tick();
        checks++;
        if (a_op !== 8'h12) begin
            errors++;
            $display("FAIL basic_a: got %h want 12", a_op);
        end
        in_data = 8'h34;
        tick();
        checks++;
        if ({b_op, out_valid, in_ready} !== {8'h34, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_b: b=%h ov=%b rdy=%b want 34/0/0", b_op, out_valid, in_ready);
        end
        tick();
        checks++;
        if ({out_valid, result, carry, zero, in_ready} !== {1'b1, 8'h46, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_latency4: ov=%b res=%h c=%b z=%b rdy=%b want 1/46/0/0/0",
                     out_valid, result, carry, zero, in_ready);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, in_ready, m, s, a_op, b_op} !== {1'b0, 1'b1, 1'b1, 2'b10, 8'h12, 8'h34}) begin
            errors++;
            $display("FAIL basic_idle_hold: ov=%b rdy=%b m=%b s=%b a=%h b=%h", out_valid, in_ready, m, s, a_op, b_op);
        end
    endtask

    task automatic test_zero_carry();
        out_ready = 1'b1;
        do_op(8'h00, 8'h80, 8'h80);
        checks++;
        if ({out_valid, result, carry, zero} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL zero_carry: ov=%b res=%h c=%b z=%b want 1/00/1/1", out_valid, result, carry, zero);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        out_ready = 1'b0;
        do_op(8'h05, 8'h0F, 8'h01);
        bad = 0;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({out_valid, in_ready, result, carry, zero, a_op, b_op} !==
                {1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 8'h0F, 8'h01})
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles, want 0", bad);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 8'h10}) begin
            errors++;
            $display("FAIL backpressure_release: ov=%b rdy=%b res=%h want 0/1/10", out_valid, in_ready, result);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_single: ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_gaps();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        tick();
        in_valid = 1'b0;
        in_data  = 8'hAA;
        tick();
        tick();
        checks++;
        if ({a_op, in_ready} !== {8'h0F, 1'b1}) begin
            errors++;
            $display("FAIL gap_a: a=%h rdy=%b want 0f/1", a_op, in_ready);
        end
        in_valid = 1'b1;
        in_data  = 8'h20;
        tick();
        in_valid = 1'b0;
        in_data  = 8'hBB;
        tick();
        tick();
        checks++;
        if ({a_op, b_op, in_ready, out_valid} !== {8'h20, 8'h01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL gap_b: a=%h b=%h rdy=%b ov=%b want 20/01/1/0", a_op, b_op, in_ready, out_valid);
        end
        in_valid = 1'b1;
        in_data  = 8'h03;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, result} !== {1'b1, 8'h23}) begin
            errors++;
            $display("FAIL gap_result: ov=%b res=%h want 1/23", out_valid, result);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h04;
        tick();
        in_data = 8'h77;
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, m, a_op} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b ov=%b m=%b a=%h want 1/0/0/00", in_ready, out_valid, m, a_op);
        end
        do_op(8'h00, 8'h01, 8'h02);
        checks++;
        if ({out_valid, result, a_op} !== {1'b1, 8'h03, 8'h01}) begin
            errors++;
            $display("FAIL mid_reset_rerun: ov=%b res=%h a=%h want 1/03/01", out_valid, result, a_op);
        end
        tick();
    endtask

    task automatic test_chain();
        out_ready = 1'b1;
        do_op(8'h06, 8'h12, 8'h34);
        tick();
        in_valid = 1'b1;
        in_data  = 8'h08;
        tick();
`ifdef ALU_SEQ_CHAIN_EN
        checks++;
        if (a_op !== 8'h46) begin
            errors++;
            $display("FAIL chain_a: got %h want 46", a_op);
        end
        in_data = 8'h01;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({b_op, in_ready} !== {8'h01, 1'b0}) begin
            errors++;
            $display("FAIL chain_skip_a: b=%h rdy=%b want 01/0", b_op, in_ready);
        end
        tick();
        checks++;
        if ({out_valid, result} !== {1'b1, 8'h47}) begin
            errors++;
            $display("FAIL chain_latency3: ov=%b res=%h want 1/47", out_valid, result);
        end
        tick();
        // A chained A after reset is zero.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h08;
        tick();
        in_data = 8'h05;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, result} !== {1'b1, 8'h05}) begin
            errors++;
            $display("FAIL chain_after_reset: ov=%b res=%h want 1/05", out_valid, result);
        end
        tick();
`else
        in_data = 8'h01;
        tick();
        checks++;
        if ({a_op, in_ready, out_valid} !== {8'h01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL nochain_waits_a: a=%h rdy=%b ov=%b want 01/1/0", a_op, in_ready, out_valid);
        end
        in_data = 8'h02;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, result} !== {1'b1, 8'h03}) begin
            errors++;
            $display("FAIL nochain_result: ov=%b res=%h want 1/03", out_valid, result);
        end
        tick();
`endif
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_zero_carry();
        test_backpressure();
        test_gaps();
        test_mid_reset();
        test_chain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
